// File: rtl/sm_controller.sv
// Instruction controller for a simple datapath: latches a 16-bit instruction and
// walks a Moore FSM that sequences register-file reads, ALU work and writeback.
module sm_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [2:0]  o_state,
    output logic [15:0] o_ir
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_WRITE_IMM = 3'd2;
    localparam logic [2:0] S_GET_A     = 3'd3;
    localparam logic [2:0] S_GET_B     = 3'd4;
    localparam logic [2:0] S_ALU       = 3'd5;
    localparam logic [2:0] S_WRITE_REG = 3'd6;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_is_alu;
    logic       w_is_movi;
    logic       w_is_movr;
    logic       w_is_cmp;
    logic       w_is_mvn;
    logic       w_uses_a;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_alu  = (w_opcode == 3'b101);
    assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
    // MVN and MOV reg only need the B operand; the other ALU ops read both.
    assign w_uses_a  = w_is_alu && !w_is_mvn;

    assign sximm8  = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5  = {{11{r_ir[4]}}, r_ir[4:0]};
    assign o_state = r_state;
    assign o_ir    = r_ir;

    // IR loads share the WAIT edge with s, so DECODE sees the freshly loaded word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (load && (r_state == S_WAIT)) begin
                r_ir <= in;
            end
        end
    end

    always_comb begin
        w_next_state = S_WAIT;
        case (r_state)
            S_WAIT:      w_next_state = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (w_is_movi)                   w_next_state = S_WRITE_IMM;
                else if (w_uses_a)               w_next_state = S_GET_A;
                else if (w_is_movr || w_is_mvn)  w_next_state = S_GET_B;
                else                             w_next_state = S_WAIT;
            end
            S_WRITE_IMM: w_next_state = S_WAIT;
            S_GET_A:     w_next_state = S_GET_B;
            S_GET_B:     w_next_state = S_ALU;
            S_ALU:       w_next_state = w_is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: w_next_state = S_WAIT;
            default:     w_next_state = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'b000;
        writenum = 3'b000;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (r_state)
            S_WAIT: w = 1'b1;
            S_WRITE_IMM: begin
                writenum = w_rn;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                shift = w_sh;
                ALUop = w_is_alu ? w_op : 2'b00;
                asel  = w_is_movr || w_is_mvn;
                loads = w_is_cmp;
                loadc = !w_is_cmp;
            end
            S_WRITE_REG: begin
                writenum = w_rd;
                vsel     = 2'b00;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sm_controller.sv
// Bench for sm_controller: directed and random instructions checked cycle by cycle
// against an instruction-level model of the expected output sequence.
module tb_sm_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  o_state;
    logic [15:0] o_ir;

    int          n_vec;
    int          n_err;
    logic [15:0] model_ir;
    logic [51:0] exp_q[$];

    sm_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .o_state  (o_state),
        .o_ir     (o_ir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word for one cycle; immediates are derived arithmetically from ir.
    function automatic logic [51:0] pack(input logic wf, input logic [2:0] rn, input logic [2:0] wn,
                                         input logic [1:0] vs, input logic la, input logic lb,
                                         input logic lc, input logic ls, input logic wr,
                                         input logic as, input logic [1:0] sh, input logic [1:0] op,
                                         input logic [15:0] ir);
        int          v8;
        int          v5;
        logic [15:0] x8;
        logic [15:0] x5;
        v8 = int'(ir[7:0]);
        if (v8 > 127) v8 = v8 - 256;
        v5 = int'(ir[4:0]);
        if (v5 > 15) v5 = v5 - 32;
        x8 = v8[15:0];
        x5 = v5[15:0];
        return {wf, rn, wn, vs, la, lb, lc, ls, wr, as, 1'b0, sh, op, x8, x5};
    endfunction

    function automatic logic [51:0] dut_bundle();
        return {w, readnum, writenum, vsel, loada, loadb, loadc, loads, write, asel, bsel,
                shift, ALUop, sximm8, sximm5};
    endfunction

    function automatic logic [51:0] idle_word(input logic [15:0] ir);
        return pack(1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ir);
    endfunction

    // Instruction-level model: list the cycles the instruction needs, one word per cycle.
    task automatic build_seq(input logic [15:0] ir);
        logic [2:0] opc;
        logic [1:0] op;
        logic       alu_i, movi, movr, cmp, mvn;
        opc   = ir[15:13];
        op    = ir[12:11];
        alu_i = (opc == 3'b101);
        movi  = (opc == 3'b110) && (op == 2'b10);
        movr  = (opc == 3'b110) && (op == 2'b00);
        cmp   = alu_i && (op == 2'b01);
        mvn   = alu_i && (op == 2'b11);
        exp_q.push_back(pack(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ir));
        if (movi) begin
            exp_q.push_back(pack(1'b0, 3'd0, ir[10:8], 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, ir));
        end else if (alu_i || movr) begin
            if (alu_i && !mvn)
                exp_q.push_back(pack(1'b0, ir[10:8], 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ir));
            exp_q.push_back(pack(1'b0, ir[2:0], 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ir));
            exp_q.push_back(pack(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, !cmp, cmp, 1'b0, movr || mvn,
                                 ir[4:3], alu_i ? op : 2'b00, ir));
            if (!cmp)
                exp_q.push_back(pack(1'b0, 3'd0, ir[7:5], 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, ir));
        end
        exp_q.push_back(idle_word(ir));
    endtask

    task automatic check(input string tag, input logic [51:0] got, input logic [51:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Starts from WAIT (just after an edge) and returns once the DUT is back in WAIT.
    task automatic run_instr(input logic [15:0] instr, input bit do_load, input bit hold_s,
                             input bit busy_load);
        logic [51:0] e;
        int          k;
        in   = instr;
        load = do_load;
        s    = 1'b1;
        if (do_load) model_ir = instr;
        build_seq(model_ir);
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("instr_%h_cyc%0d", model_ir, k), dut_bundle(), e);
            k++;
            if (exp_q.size() != 0) begin
                s    = hold_s;
                load = busy_load;
                if (busy_load) in = 16'($urandom);
            end else begin
                load = 1'b0;
            end
        end
        check($sformatf("ir_after_%h", model_ir), {36'd0, o_ir}, {36'd0, model_ir});
    endtask

    initial begin
        logic [15:0] r_instr;
        int          pick;
        n_vec    = 0;
        n_err    = 0;
        model_ir = 16'h0000;
        reset_n  = 1'b0;
        in       = 16'h0000;
        load     = 1'b0;
        s        = 1'b0;

        #3;
        check("reset_async", dut_bundle(), idle_word(16'h0000));
        check("reset_ir", {36'd0, o_ir}, 52'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", dut_bundle(), idle_word(16'h0000));

        run_instr(16'hD007, 1, 0, 0);
        run_instr(16'hD1FE, 1, 0, 0);
        run_instr(16'hA148, 1, 0, 1);
        run_instr(16'hA900, 1, 0, 0);
        run_instr(16'h0000, 1, 0, 0);
        run_instr(16'hC05A, 1, 0, 0);
        run_instr(16'hB86B, 1, 0, 1);
        run_instr(16'hB2F1, 1, 0, 0);
        run_instr(16'hF123, 1, 0, 0);
        run_instr(16'hA148, 1, 1, 1);
        run_instr(16'hA148, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 7);
            r_instr = 16'($urandom);
            case (pick)
                0: r_instr[15:11] = 5'b11010;
                1: r_instr[15:11] = 5'b11000;
                2: r_instr[15:11] = 5'b10100;
                3: r_instr[15:11] = 5'b10101;
                4: r_instr[15:11] = 5'b10110;
                5: r_instr[15:11] = 5'b10111;
                default: ;
            endcase
            run_instr(r_instr, $urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1);
        end
        s = 1'b0;

        // Abort an ADD while it sits in GET_B.
        in   = 16'hA148;
        load = 1'b1;
        s    = 1'b1;
        model_ir = 16'hA148;
        @(posedge clk);
        #1;
        s    = 1'b0;
        load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_get_b", dut_bundle(),
              pack(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'hA148));
        #3;
        reset_n  = 1'b0;
        model_ir = 16'h0000;
        #1;
        check("abort_async", dut_bundle(), idle_word(16'h0000));
        check("abort_ir", {36'd0, o_ir}, 52'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_held_%0d", i), dut_bundle(), idle_word(16'h0000));
        end
        reset_n = 1'b1;
        run_instr(16'hD007, 1, 0, 0);
        run_instr(16'hA900, 1, 0, 0);

        @(posedge clk);
        #1;
        check("final_idle", dut_bundle(), idle_word(model_ir));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
